// File: rtl/run_ctrl_if.sv
// run_ctrl_if: harness/core signal bundle for the run controller.
// master = harness + program-counter model, slave = run_ctrl.
// Harness side:  Start (req level), Ack, timeout, cycle_count, last_pc.
// Core side:     init, run (to core), halt, pc (from program counter).
interface run_ctrl_if #(
   parameter int PC_W  = 10,
   parameter int CNT_W = 16
);
   logic             Start;
   logic             halt;
   logic [PC_W-1:0]  pc;
   logic             init;
   logic             run;
   logic             Ack;
   logic             timeout;
   logic [CNT_W-1:0] cycle_count;
   logic [PC_W-1:0]  last_pc;

   modport master (
      output Start, halt, pc,
      input  init, run, Ack, timeout,
      input  cycle_count, last_pc
   );

   modport slave (
      input  Start, halt, pc,
      output init, run, Ack, timeout,
      output cycle_count, last_pc
   );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: IDLE/INIT/RUN/DONE controller holding the core in init,
// releasing it to run, counting RUN cycles with a watchdog, and
// reporting completion on Ack.
// Ports: CLK, Reset (sync, active high), bus (run_ctrl_if.slave).
module run_ctrl #(
   parameter int INIT_CYCLES = 2,
   parameter int MAX_CYCLES  = 20000,
   parameter int CNT_W       = 16,
   parameter int PC_W        = 10
) (
   input logic       CLK,
   input logic       Reset,
   run_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      RUN,
      DONE
   } state_t;

   localparam int IW = $clog2(INIT_CYCLES + 1);
   localparam logic [IW-1:0] INIT_MAX = IW'(INIT_CYCLES);

   localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;
   // With a too-narrow counter the count saturates before the
   // watchdog value can be reached, so the compare is disabled.
   localparam bit WD_EN = (64'(MAX_CYCLES) <= CNT_MAX);
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0] WD_VAL  = CNT_W'(MAX_CYCLES);

   if (!WD_EN) begin : g_wd_chk
      $warning("run_ctrl: MAX_CYCLES exceeds cycle_count range");
   end

   state_t           state_q;
   logic             init_q;
   logic             run_q;
   logic             ack_q;
   logic             to_q;
   logic [CNT_W-1:0] cyc_q;
   logic [CNT_W-1:0] cyc_d;
   logic [PC_W-1:0]  pc_q;
   logic [IW-1:0]    icnt_q;
   logic [IW-1:0]    icnt_d;
   logic             go_init;

   assign cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
   assign icnt_d = (icnt_q >= INIT_MAX) ? INIT_MAX
                                        : icnt_q + 1'b1;

   // Start restarts from any state except INIT, which just holds.
   assign go_init = bus.Start && (state_q != INIT);

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= IDLE;
         init_q  <= 1'b1;
         run_q   <= 1'b0;
         ack_q   <= 1'b0;
         to_q    <= 1'b0;
         cyc_q   <= '0;
         pc_q    <= '0;
         icnt_q  <= '0;
      end else if (go_init) begin
         state_q <= INIT;
         init_q  <= 1'b1;
         run_q   <= 1'b0;
         ack_q   <= 1'b0;
         to_q    <= 1'b0;
         cyc_q   <= '0;
         pc_q    <= '0;
         icnt_q  <= '0;
      end else begin
         unique case (state_q)
            INIT: begin
               // icnt_d counts the INIT cycle now ending, giving a
               // dwell of exactly INIT_CYCLES when Start is low.
               icnt_q <= icnt_d;
               if (icnt_d >= INIT_MAX && !bus.Start) begin
                  state_q <= RUN;
                  init_q  <= 1'b0;
                  run_q   <= 1'b1;
               end
            end
            RUN: begin
               if (bus.halt) begin
                  state_q <= DONE;
                  run_q   <= 1'b0;
                  ack_q   <= 1'b1;
                  pc_q    <= bus.pc;
               end else if (WD_EN && cyc_q == WD_LAST) begin
                  state_q <= DONE;
                  run_q   <= 1'b0;
                  ack_q   <= 1'b1;
                  to_q    <= 1'b1;
                  pc_q    <= bus.pc;
                  cyc_q   <= WD_VAL;
               end else begin
                  cyc_q <= cyc_d;
               end
            end
            IDLE, DONE: begin
               state_q <= state_q;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.init        = init_q;
   assign bus.run         = run_q;
   assign bus.Ack         = ack_q;
   assign bus.timeout     = to_q;
   assign bus.cycle_count = cyc_q;
   assign bus.last_pc     = pc_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed bench for run_ctrl (default watchdog and a
// second instance with MAX_CYCLES=8 driven by the same stimulus).
module tb_run_ctrl;

   logic       CLK;
   logic       Reset;
   logic       start;
   logic       halt;
   logic [9:0] pc;

   int tests;
   int fails;
   int run_cnt;
   int wd_cnt;
   int n;

   run_ctrl_if #(.PC_W(10), .CNT_W(16)) m_if ();
   run_ctrl_if #(.PC_W(10), .CNT_W(16)) w_if ();

   assign m_if.Start = start;
   assign m_if.halt  = halt;
   assign m_if.pc    = pc;
   assign w_if.Start = start;
   assign w_if.halt  = halt;
   assign w_if.pc    = pc;

   run_ctrl #(
      .INIT_CYCLES(2), .MAX_CYCLES(20000),
      .CNT_W(16), .PC_W(10)
   ) dut (
      .CLK(CLK), .Reset(Reset), .bus(m_if.slave)
   );

   run_ctrl #(
      .INIT_CYCLES(2), .MAX_CYCLES(8),
      .CNT_W(16), .PC_W(10)
   ) dut_wd (
      .CLK(CLK), .Reset(Reset), .bus(w_if.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
      if (m_if.run) run_cnt++;
      if (w_if.run) wd_cnt++;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d",
                tag, obs, exp);
      end
   endtask

   task automatic wait_run(output int cnt);
      cnt = 0;
      while (!m_if.run && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("run_rise", 32'(m_if.run), 1);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      run_cnt = 0;
      wd_cnt = 0;
      start = 1'b1;
      halt = 1'b0;
      pc = '0;
      Reset = 1'b1;

      // Reset with Start high
      tick();
      tick();
      chk("rst_init", 32'(m_if.init), 1);
      chk("rst_ack", 32'(m_if.Ack), 0);
      chk("rst_run", 32'(m_if.run), 0);
      chk("rst_to", 32'(m_if.timeout), 0);
      chk("rst_cc", 32'(m_if.cycle_count), 0);
      chk("rst_lpc", 32'(m_if.last_pc), 0);
      Reset = 1'b0;
      start = 1'b0;
      repeat (3) tick();
      chk("idle_hold_run", 32'(m_if.run), 0);
      chk("idle_hold_init", 32'(m_if.init), 1);

      // Basic run: halt on 6th RUN cycle, pc=37
      start = 1'b1;
      run_cnt = 0;
      tick();
      chk("b_start_init", 32'(m_if.init), 1);
      chk("b_start_ack", 32'(m_if.Ack), 0);
      start = 1'b0;
      wait_run(n);
      chk("b_dwell_ge2", 32'(n >= 2), 1);
      chk("b_init_low", 32'(m_if.init), 0);
      repeat (5) tick();
      halt = 1'b1;
      pc = 10'd37;
      tick();
      halt = 1'b0;
      pc = 10'd3;
      chk("b_ack", 32'(m_if.Ack), 1);
      chk("b_run", 32'(m_if.run), 0);
      chk("b_runcyc", 32'(run_cnt), 6);
      chk("b_cc", 32'(m_if.cycle_count), 5);
      chk("b_lpc", 32'(m_if.last_pc), 37);
      chk("b_to", 32'(m_if.timeout), 0);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      tick();
      chk("b_hold_ack", 32'(m_if.Ack), 1);
      chk("b_hold_cc", 32'(m_if.cycle_count), 5);
      chk("b_hold_lpc", 32'(m_if.last_pc), 37);

      // Long Start: 10 cycles high
      start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("l_init", 32'(m_if.init), 1);
         chk("l_run", 32'(m_if.run), 0);
      end
      chk("l_ack", 32'(m_if.Ack), 0);
      start = 1'b0;
      tick();
      chk("l_run_next", 32'(m_if.run), 1);
      chk("l_init_next", 32'(m_if.init), 0);
      halt = 1'b1;
      pc = 10'd5;
      tick();
      halt = 1'b0;
      chk("l_cc0", 32'(m_if.cycle_count), 0);
      chk("l_lpc", 32'(m_if.last_pc), 5);
      chk("l_ack1", 32'(m_if.Ack), 1);

      // Watchdog on MAX_CYCLES=8 instance
      start = 1'b1;
      tick();
      start = 1'b0;
      pc = 10'd99;
      wd_cnt = 0;
      wait_run(n);
      n = 0;
      while (!w_if.Ack && n < 20) begin
         tick();
         n++;
      end
      chk("wd_ack", 32'(w_if.Ack), 1);
      chk("wd_runcyc", 32'(wd_cnt), 8);
      chk("wd_to", 32'(w_if.timeout), 1);
      chk("wd_cc", 32'(w_if.cycle_count), 8);
      chk("wd_lpc", 32'(w_if.last_pc), 99);
      chk("wd_run0", 32'(w_if.run), 0);
      chk("main_run", 32'(m_if.run), 1);
      chk("main_cc", 32'(m_if.cycle_count), 8);
      chk("main_to", 32'(m_if.timeout), 0);

      // Abort on RUN cycle 3, then a normal run
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_run(n);
      repeat (2) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ab_init", 32'(m_if.init), 1);
      chk("ab_run", 32'(m_if.run), 0);
      chk("ab_cc", 32'(m_if.cycle_count), 0);
      chk("ab_ack", 32'(m_if.Ack), 0);
      wait_run(n);
      chk("ab_ack_none", 32'(m_if.Ack), 0);
      repeat (2) tick();
      halt = 1'b1;
      pc = 10'd12;
      tick();
      chk("ab2_ack", 32'(m_if.Ack), 1);
      chk("ab2_cc", 32'(m_if.cycle_count), 2);
      chk("ab2_lpc", 32'(m_if.last_pc), 12);

      // Back-to-back: Start in the first Ack cycle
      halt = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b_ack", 32'(m_if.Ack), 0);
      chk("b2b_init", 32'(m_if.init), 1);
      chk("b2b_lpc", 32'(m_if.last_pc), 0);

      // Simultaneous Start and halt in RUN
      wait_run(n);
      tick();
      start = 1'b1;
      halt = 1'b1;
      pc = 10'd77;
      tick();
      start = 1'b0;
      halt = 1'b0;
      chk("sim_init", 32'(m_if.init), 1);
      chk("sim_run", 32'(m_if.run), 0);
      chk("sim_ack", 32'(m_if.Ack), 0);
      chk("sim_lpc", 32'(m_if.last_pc), 0);
      chk("sim_cc", 32'(m_if.cycle_count), 0);

      // Reset mid-RUN
      wait_run(n);
      repeat (3) tick();
      Reset = 1'b1;
      tick();
      chk("mr_init", 32'(m_if.init), 1);
      chk("mr_run", 32'(m_if.run), 0);
      chk("mr_cc", 32'(m_if.cycle_count), 0);
      Reset = 1'b0;
      repeat (3) tick();
      chk("mr_idle", 32'(m_if.run), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

endmodule
